// File: rtl/mem_ctrl.sv
// mem_ctrl: I-cache and write-through D-cache responder with one handshaked backing-memory port.
// Define MEM_STATS_EN to add the i_miss_cnt / d_miss_cnt saturating miss counters.
module mem_ctrl #(
    parameter int unsigned I_LINES   = 8,
    parameter int unsigned D_LINES   = 8,
    parameter logic [15:0] NOP_INSTR = 16'hB0FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_acc,
    input  logic [15:0] i_addr,
    input  logic        d_rd_acc,
    input  logic        d_wr_acc,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wrt_data,
    output logic        stall,
    output logic [15:0] instr,
    output logic [15:0] data,
    output logic        m_req,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic        m_rdy,
    input  logic [63:0] m_rdata
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] i_miss_cnt,
    output logic [15:0] d_miss_cnt
`endif
);

    localparam int unsigned IIW = $clog2(I_LINES);
    localparam int unsigned DIW = $clog2(D_LINES);
    localparam int unsigned ITW = 14 - IIW;
    localparam int unsigned DTW = 14 - DIW;

    typedef enum logic [1:0] {IDLE, D_WR, D_FILL, I_FILL} state_t;

    state_t             r_state;
    logic               r_wr_done;

    logic [I_LINES-1:0] r_i_valid;
    logic [ITW-1:0]     r_i_tag  [I_LINES];
    logic [15:0]        r_i_data [I_LINES][4];
    logic [D_LINES-1:0] r_d_valid;
    logic [DTW-1:0]     r_d_tag  [D_LINES];
    logic [15:0]        r_d_data [D_LINES][4];

    logic [IIW-1:0]     w_i_idx;
    logic [ITW-1:0]     w_i_tag;
    logic [DIW-1:0]     w_d_idx;
    logic [DTW-1:0]     w_d_tag;
    logic               w_i_line_hit;
    logic               w_d_line_hit;
    logic               w_i_hit;
    logic               w_d_hit;
    logic               w_wr_pend;
    logic               w_d_miss;
    logic               w_i_miss;
    logic               w_idle;
    logic               w_go_wr;
    logic               w_go_dfill;
    logic               w_go_ifill;

    // Address split and same-cycle hit lookup
    assign w_i_idx      = i_addr[2 +: IIW];
    assign w_i_tag      = i_addr[15 -: ITW];
    assign w_d_idx      = d_addr[2 +: DIW];
    assign w_d_tag      = d_addr[15 -: DTW];
    assign w_i_line_hit = r_i_valid[w_i_idx] && (r_i_tag[w_i_idx] == w_i_tag);
    assign w_d_line_hit = r_d_valid[w_d_idx] && (r_d_tag[w_d_idx] == w_d_tag);
    assign w_i_hit      = i_acc & w_i_line_hit;
    assign w_d_hit      = d_rd_acc & w_d_line_hit;

    assign instr = w_i_hit ? r_i_data[w_i_idx][i_addr[1:0]] : NOP_INSTR;
    assign data  = w_d_hit ? r_d_data[w_d_idx][d_addr[1:0]] : 16'h0000;

    assign w_wr_pend = d_wr_acc & ~r_wr_done;
    assign w_d_miss  = d_rd_acc & ~w_d_line_hit;
    assign w_i_miss  = i_acc & ~w_i_line_hit;
    assign w_idle    = (r_state == IDLE);
    assign stall     = ~w_idle | w_wr_pend | w_d_miss | w_i_miss;

    // Data requests win over instruction fetches; one backing transaction at a time
    assign w_go_wr    = w_idle & w_wr_pend;
    assign w_go_dfill = w_idle & ~w_wr_pend & w_d_miss;
    assign w_go_ifill = w_idle & ~w_wr_pend & ~w_d_miss & w_i_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wr_done <= 1'b0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= 16'h0000;
            m_wdata   <= 16'h0000;
            r_i_valid <= '0;
            r_d_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!stall) begin
                        r_wr_done <= 1'b0;
                    end
                    if (w_go_wr) begin
                        r_state <= D_WR;
                        m_req   <= 1'b1;
                        m_we    <= 1'b1;
                        m_addr  <= d_addr;
                        m_wdata <= d_wrt_data;
                    end else if (w_go_dfill) begin
                        r_state <= D_FILL;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= {d_addr[15:2], 2'b00};
                    end else if (w_go_ifill) begin
                        r_state <= I_FILL;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= {i_addr[15:2], 2'b00};
                    end
                end
                D_WR: begin
                    if (m_rdy) begin
                        r_state   <= IDLE;
                        m_req     <= 1'b0;
                        r_wr_done <= 1'b1;
                    end
                end
                D_FILL: begin
                    if (m_rdy) begin
                        r_state            <= IDLE;
                        m_req              <= 1'b0;
                        r_d_valid[w_d_idx] <= 1'b1;
                    end
                end
                I_FILL: begin
                    if (m_rdy) begin
                        r_state            <= IDLE;
                        m_req              <= 1'b0;
                        r_i_valid[w_i_idx] <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line storage; only the valid bits need a reset
    always_ff @(posedge clk) begin
        if (r_state == I_FILL && m_rdy) begin
            r_i_tag[w_i_idx] <= w_i_tag;
            for (int k = 0; k < 4; k++) begin
                r_i_data[w_i_idx][k] <= m_rdata[16*k +: 16];
            end
        end
        if (r_state == D_FILL && m_rdy) begin
            r_d_tag[w_d_idx] <= w_d_tag;
            for (int k = 0; k < 4; k++) begin
                r_d_data[w_d_idx][k] <= m_rdata[16*k +: 16];
            end
        end
        if (r_state == D_WR && m_rdy && w_d_line_hit) begin
            r_d_data[w_d_idx][d_addr[1:0]] <= d_wrt_data;
        end
    end

`ifdef MEM_STATS_EN
    // Saturating miss counters, bumped on entry into a fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_miss_cnt <= 16'h0000;
            d_miss_cnt <= 16'h0000;
        end else begin
            if (w_go_ifill && i_miss_cnt != 16'hFFFF) begin
                i_miss_cnt <= i_miss_cnt + 16'd1;
            end
            if (w_go_dfill && d_miss_cnt != 16'hFFFF) begin
                d_miss_cnt <= d_miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
